ring_port_rr_arbiter: RTL and testbench

Packet-aware round-robin arbiter for one ring router output port. It shares the link between NREQ requesters (default: local injection, clockwise input, counter-clockwise input). A grant locks from the head flit to the tail flit so packets are never interleaved. Fairness comes from a rotating priority pointer, which replaces fixed-priority selection on this port.

---
 rtl/ring_port_rr_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ring_port_rr_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ring_port_rr_arbiter.sv
// ring_port_rr_arbiter
// Packet-aware round-robin arbiter for one ring-router output port.
// A grant is taken on a head flit and held until that requester's tail flit
// is transferred, so packets from different requesters never interleave.
// After each release the rotating pointer moves just past the releasing
// requester, which gives every pending requester a fair turn.
//
// Optional feature macro: ARB_PKT_LIMIT_EN
//   When defined, a flit counter forces a release after MAX_FLITS flits
//   without a tail and pulses err_pkt_len for one cycle. When undefined,
//   the counter is absent and err_pkt_len is tied low.
module ring_port_rr_arbiter #(
  parameter int NREQ      = 3,
  parameter int MAX_FLITS = 16,
  parameter int CW        = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] tail,
  input  logic            out_ready,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic            xfer,
  output logic [2:0]      ptr,
  output logic            err_pkt_len
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [2:0] LAST = 3'(NREQ - 1);

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [2:0]      g_idx;
  logic [2:0]      nxt_ptr;
  logic            req_g;
  logic            tail_g;
  logic            xfer_w;
  logic            limit_hit;
  logic            release_w;

  // First set request scanning p, p+1, ... with wrap: rotate the request
  // vector so p sits at bit 0, isolate the lowest set bit, rotate back.
  function automatic logic [NREQ-1:0] rr_pick(input logic [2:0]      p,
                                              input logic [NREQ-1:0] r);
    logic [2*NREQ-1:0] dbl;
    logic [2*NREQ-1:0] back;
    logic [NREQ-1:0]   rot;
    logic [NREQ-1:0]   oh;
    dbl  = {r, r} >> p;
    rot  = dbl[NREQ-1:0];
    oh   = rot & (~rot + NREQ'(1));
    back = {oh, oh} << p;
    return back[2*NREQ-1:NREQ];
  endfunction

  // Binary index of the current grant holder (gnt_q is one-hot or zero).
  always_comb begin
    g_idx = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      if ((gnt_q & (NREQ'(1) << i)) != '0) g_idx = 3'(i);
    end
  end

  assign req_g   = |(gnt_q & req);
  assign tail_g  = |(gnt_q & tail);
  assign xfer_w  = (state_q == GRANT) & req_g & out_ready;
  assign nxt_ptr = (g_idx == LAST) ? 3'd0 : g_idx + 3'd1;

`ifdef ARB_PKT_LIMIT_EN
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // A packet that has already moved MAX_FLITS-1 flits without a tail is cut
  // off on its next non-tail transfer.
  assign limit_hit = (cnt_q == CW'(MAX_FLITS - 1)) & ~tail_g;

  // Flit counter and forced-release pulse next state.
  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (release_w) begin
      cnt_d = '0;
      err_d = limit_hit;
    end else if (xfer_w) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Flit counter and error pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_pkt_len = err_q;
`else
  logic unused_cfg;

  assign limit_hit   = 1'b0;
  assign err_pkt_len = 1'b0;
  assign unused_cfg  = (MAX_FLITS > 0) ^ (CW > 0);
`endif

  assign release_w = xfer_w & (tail_g | limit_hit);

  // Next-state logic: grant from IDLE, hold through the packet, and on
  // release re-arbitrate in the same edge from the advanced pointer.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          gnt_d   = rr_pick(ptr_q, req);
        end
      end
      GRANT: begin
        if (release_w) begin
          ptr_d   = nxt_ptr;
          gnt_d   = rr_pick(nxt_ptr, req);
          state_d = (|req) ? GRANT : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State, grant and pointer registers; reset drops any grant at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = (state_q == GRANT);
  assign xfer = xfer_w;
  assign ptr  = ptr_q;

endmodule

// File: tb/tb_ring_port_rr_arbiter.sv
// tb_ring_port_rr_arbiter
// Directed vectors for the ring port arbiter. Each stimulus cycle pushes the
// hand-computed outputs expected for that cycle into a queue; a monitor on the
// falling edge pops and compares them against the DUT.
module tb_ring_port_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [2:0] req;
  logic [2:0] tail;
  logic       out_ready;
  logic [2:0] gnt;
  logic       busy;
  logic       xfer;
  logic [2:0] ptr;
  logic       err_pkt_len;

  logic [8:0] exp_q[$];
  int         id_q[$];
  int         vec_n;
  int         n_cmp;
  int         n_bad;

  ring_port_rr_arbiter #(
    .NREQ     (3),
    .MAX_FLITS(4),
    .CW       (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .tail       (tail),
    .out_ready  (out_ready),
    .gnt        (gnt),
    .busy       (busy),
    .xfer       (xfer),
    .ptr        (ptr),
    .err_pkt_len(err_pkt_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare every presented cycle that has an expectation queued.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [8:0] e;
      logic [8:0] a;
      int         id;
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      a  = {gnt, busy, xfer, ptr, err_pkt_len};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL vec%0d gnt/busy/xfer/ptr/err got %b/%b/%b/%0d/%b required %b/%b/%b/%0d/%b",
                 id, a[8:6], a[5], a[4], a[3:1], a[0], e[8:6], e[5], e[4], e[3:1], e[0]);
      end
    end
  end

  // One cycle: drive inputs, queue the outputs expected during this cycle.
  task automatic step(input logic [2:0] r, input logic [2:0] t, input logic o,
                      input logic [2:0] eg, input logic eb, input logic ex,
                      input logic [2:0] ep, input logic ee);
    req       = r;
    tail      = t;
    out_ready = o;
    exp_q.push_back({eg, eb, ex, ep, ee});
    id_q.push_back(vec_n);
    vec_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req       = 3'b000;
    tail      = 3'b000;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    vec_n = 0;
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    req   = 3'b000;
    tail  = 3'b000;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: all requesting single-flit packets rotate one per cycle.
    do_reset();
    step(3'b111, 3'b111, 1'b1, 3'b000, 1'b0, 1'b0, 3'd0, 1'b0);
    step(3'b111, 3'b111, 1'b1, 3'b001, 1'b1, 1'b1, 3'd0, 1'b0);
    step(3'b111, 3'b111, 1'b1, 3'b010, 1'b1, 1'b1, 3'd1, 1'b0);
    step(3'b111, 3'b111, 1'b1, 3'b100, 1'b1, 1'b1, 3'd2, 1'b0);
    step(3'b111, 3'b111, 1'b1, 3'b001, 1'b1, 1'b1, 3'd0, 1'b0);

    // Test 2: 4-flit packet on requester 1, requester 0 joins at flit 2;
    // a tail from non-granted requester 0 is ignored.
    do_reset();
    step(3'b010, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 3'd0, 1'b0);
    step(3'b010, 3'b000, 1'b1, 3'b010, 1'b1, 1'b1, 3'd0, 1'b0);
    step(3'b011, 3'b001, 1'b1, 3'b010, 1'b1, 1'b1, 3'd0, 1'b0);
    step(3'b011, 3'b000, 1'b1, 3'b010, 1'b1, 1'b1, 3'd0, 1'b0);
    step(3'b011, 3'b010, 1'b1, 3'b010, 1'b1, 1'b1, 3'd0, 1'b0);
    step(3'b011, 3'b000, 1'b1, 3'b001, 1'b1, 1'b1, 3'd2, 1'b0);

    // Test 3: requester 0 gaps for two cycles mid-packet, requester 1 waits.
    do_reset();
    step(3'b001, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 3'd0, 1'b0);
    step(3'b011, 3'b000, 1'b1, 3'b001, 1'b1, 1'b1, 3'd0, 1'b0);
    step(3'b010, 3'b000, 1'b1, 3'b001, 1'b1, 1'b0, 3'd0, 1'b0);
    step(3'b010, 3'b001, 1'b1, 3'b001, 1'b1, 1'b0, 3'd0, 1'b0);
    step(3'b011, 3'b000, 1'b1, 3'b001, 1'b1, 1'b1, 3'd0, 1'b0);
    step(3'b011, 3'b001, 1'b1, 3'b001, 1'b1, 1'b1, 3'd0, 1'b0);
    step(3'b010, 3'b000, 1'b1, 3'b010, 1'b1, 1'b1, 3'd1, 1'b0);

    // Test 4: five stall cycles mid-packet on requester 2; pointer wraps.
    do_reset();
    step(3'b100, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 3'd0, 1'b0);
    step(3'b100, 3'b000, 1'b1, 3'b100, 1'b1, 1'b1, 3'd0, 1'b0);
    for (int i = 0; i < 5; i++)
      step(3'b100, 3'b100, 1'b0, 3'b100, 1'b1, 1'b0, 3'd0, 1'b0);
    step(3'b110, 3'b000, 1'b1, 3'b100, 1'b1, 1'b1, 3'd0, 1'b0);
    step(3'b110, 3'b100, 1'b1, 3'b100, 1'b1, 1'b1, 3'd0, 1'b0);
    step(3'b010, 3'b000, 1'b1, 3'b010, 1'b1, 1'b1, 3'd0, 1'b0);

    // Test 5: reset during flit 2 of a requester-2 packet (ptr nonzero).
    do_reset();
    step(3'b101, 3'b101, 1'b1, 3'b000, 1'b0, 1'b0, 3'd0, 1'b0);
    step(3'b101, 3'b001, 1'b1, 3'b001, 1'b1, 1'b1, 3'd0, 1'b0);
    step(3'b100, 3'b000, 1'b1, 3'b100, 1'b1, 1'b1, 3'd1, 1'b0);
    rst = 1'b1;
    step(3'b100, 3'b000, 1'b1, 3'b100, 1'b1, 1'b1, 3'd1, 1'b0);
    rst = 1'b0;
    step(3'b100, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 3'd0, 1'b0);
    step(3'b100, 3'b000, 1'b1, 3'b100, 1'b1, 1'b1, 3'd0, 1'b0);

    // Test 6: requester 1 streams flits with no tail while requester 2 waits.
    do_reset();
    step(3'b010, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 3'd0, 1'b0);
    step(3'b110, 3'b000, 1'b1, 3'b010, 1'b1, 1'b1, 3'd0, 1'b0);
    step(3'b110, 3'b000, 1'b1, 3'b010, 1'b1, 1'b1, 3'd0, 1'b0);
    step(3'b110, 3'b000, 1'b1, 3'b010, 1'b1, 1'b1, 3'd0, 1'b0);
    step(3'b110, 3'b000, 1'b1, 3'b010, 1'b1, 1'b1, 3'd0, 1'b0);
`ifdef ARB_PKT_LIMIT_EN
    step(3'b110, 3'b000, 1'b1, 3'b100, 1'b1, 1'b1, 3'd2, 1'b1);
    step(3'b110, 3'b000, 1'b1, 3'b100, 1'b1, 1'b1, 3'd2, 1'b0);
`else
    step(3'b110, 3'b000, 1'b1, 3'b010, 1'b1, 1'b1, 3'd0, 1'b0);
    step(3'b110, 3'b000, 1'b1, 3'b010, 1'b1, 1'b1, 3'd0, 1'b0);
`endif

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog time=%0t required finish earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule
